// File: rtl/sram_pair_fetch_if.sv
// Valid/ready stream carrying fetched SRAM word pairs out of sram_pair_fetch.
// The master drives the head entry; the slave accepts it with out_ready.
interface sram_pair_fetch_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic                  out_valid;
    logic                  out_ready;
    logic [2*DATA_W-1:0]   out_data;
    logic [ADDR_W-1:0]     out_addr;

    modport master (
        output out_valid,
        output out_data,
        output out_addr,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_addr,
        output out_ready
    );
endinterface

// File: rtl/sram_pair_fetch.sv
// Issues dual-port SRAM reads per address pair, tracks the fixed read latency and
// buffers joined pairs in a FIFO. Define PAIR_CHECK_EN to enable address-pair checking.
module sram_pair_fetch #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 8,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 addr_valid_i,
    input  logic [ADDR_W-1:0]    addr_even_i,
    input  logic [ADDR_W-1:0]    addr_odd_i,
    output logic                 sram_re_o,
    output logic [ADDR_W-1:0]    sram_addr_a_o,
    output logic [ADDR_W-1:0]    sram_addr_b_o,
    input  logic [DATA_W-1:0]    sram_rdata_a_i,
    input  logic [DATA_W-1:0]    sram_rdata_b_i,
    sram_pair_fetch_if.master    out_if,
    output logic                 overflow_o,
    output logic [7:0]           drop_count_o,
    output logic                 pair_err_o
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_W + 2 * DATA_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic                 sram_re_q;
    logic [ADDR_W-1:0]    sram_addr_a_q;
    logic [ADDR_W-1:0]    sram_addr_b_q;
    logic [RD_LAT:0]      lat_v_q;
    logic [ADDR_W-1:0]    lat_addr_q [RD_LAT+1];
    logic [ENTRY_W-1:0]   fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic [7:0]           drop_cnt_q, drop_cnt_d;
    logic                 pop_s, cand_s, push_s, drop_s, head_valid_s;
    logic [ENTRY_W-1:0]   head_s;

    // Request stage: addresses hold while no pair is presented.
    always_ff @(posedge clock) begin
        if (reset) begin
            sram_re_q     <= 1'b0;
            sram_addr_a_q <= '0;
            sram_addr_b_q <= '0;
        end else begin
            sram_re_q <= addr_valid_i;
            if (addr_valid_i) begin
                sram_addr_a_q <= addr_even_i;
                sram_addr_b_q <= addr_odd_i;
            end
        end
    end

    // Latency pipe: stage RD_LAT lines up with the returned read data.
    always_ff @(posedge clock) begin
        if (reset) begin
            lat_v_q <= '0;
            for (int i = 0; i <= RD_LAT; i++) begin
                lat_addr_q[i] <= '0;
            end
        end else begin
            lat_v_q       <= {lat_v_q[RD_LAT-1:0], addr_valid_i};
            lat_addr_q[0] <= addr_even_i;
            for (int i = 1; i <= RD_LAT; i++) begin
                lat_addr_q[i] <= lat_addr_q[i-1];
            end
        end
    end

    always_comb begin
        head_valid_s = (count_q != '0);
        pop_s        = head_valid_s && out_if.out_ready;
        cand_s       = lat_v_q[RD_LAT];
        push_s       = cand_s && ((count_q < DEPTH_C) || pop_s);
        drop_s       = cand_s && !push_s;
        wr_ptr_d     = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d     = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        overflow_d = overflow_q | drop_s;
        if (drop_s && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // FIFO control and drop accounting.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // FIFO storage: contents are only meaningful below count_q, so no reset is needed.
    always_ff @(posedge clock) begin
        if (!reset && push_s) begin
            fifo_mem_q[wr_ptr_q] <= {lat_addr_q[RD_LAT], sram_rdata_b_i, sram_rdata_a_i};
        end
    end

    assign head_s           = fifo_mem_q[rd_ptr_q];
    assign out_if.out_valid = head_valid_s;
    assign out_if.out_data  = head_valid_s ? head_s[2*DATA_W-1:0] : '0;
    assign out_if.out_addr  = head_valid_s ? head_s[ENTRY_W-1 -: ADDR_W] : '0;
    assign sram_re_o        = sram_re_q;
    assign sram_addr_a_o    = sram_addr_a_q;
    assign sram_addr_b_o    = sram_addr_b_q;
    assign overflow_o       = overflow_q;
    assign drop_count_o     = drop_cnt_q;

`ifdef PAIR_CHECK_EN
    logic                 pair_err_q;
    logic [ADDR_W-1:0]    prev_even_q;
    logic                 have_prev_q;
    logic                 form_bad_s, seq_bad_s, pair_bad_s;

    always_comb begin
        form_bad_s = (addr_odd_i != (addr_even_i + ADDR_W'(1))) || addr_even_i[0];
        seq_bad_s  = have_prev_q && (addr_even_i != (prev_even_q + ADDR_W'(2)));
        pair_bad_s = addr_valid_i && (form_bad_s || seq_bad_s);
    end

    // Sticky pair error; the sequence check needs one prior valid pair.
    always_ff @(posedge clock) begin
        if (reset) begin
            pair_err_q  <= 1'b0;
            prev_even_q <= '0;
            have_prev_q <= 1'b0;
        end else begin
            pair_err_q <= pair_err_q | pair_bad_s;
            if (addr_valid_i) begin
                prev_even_q <= addr_even_i;
                have_prev_q <= 1'b1;
            end
        end
    end

    assign pair_err_o = pair_err_q;
`else
    assign pair_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sram_pair_fetch.sv
// Randomized self-checking bench for sram_pair_fetch against a queue-based model
// of the request latency, FIFO capacity, drop and pair-check rules.
module tb_sram_pair_fetch;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 8;
    localparam int RD_LAT     = 1;
    localparam int FIFO_DEPTH = 4;

    typedef struct {
        logic [ADDR_W-1:0] e;
        logic [ADDR_W-1:0] o;
        int                due;
    } req_t;

    typedef struct {
        logic [ADDR_W-1:0]   addr;
        logic [2*DATA_W-1:0] data;
    } ent_t;

    logic                clock = 1'b0;
    logic                reset;
    logic                addr_valid;
    logic [ADDR_W-1:0]   addr_even, addr_odd;
    logic                sram_re;
    logic [ADDR_W-1:0]   sram_addr_a, sram_addr_b;
    logic [DATA_W-1:0]   sram_rdata_a, sram_rdata_b;
    logic                overflow;
    logic [7:0]          drop_count;
    logic                pair_err;

    sram_pair_fetch_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) out_if ();

    sram_pair_fetch #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .addr_valid_i  (addr_valid),
        .addr_even_i   (addr_even),
        .addr_odd_i    (addr_odd),
        .sram_re_o     (sram_re),
        .sram_addr_a_o (sram_addr_a),
        .sram_addr_b_o (sram_addr_b),
        .sram_rdata_a_i(sram_rdata_a),
        .sram_rdata_b_i(sram_rdata_b),
        .out_if        (out_if),
        .overflow_o    (overflow),
        .drop_count_o  (drop_count),
        .pair_err_o    (pair_err)
    );

    always #5 clock = ~clock;

    function automatic logic [DATA_W-1:0] sram_word(input logic [ADDR_W-1:0] a);
        return DATA_W'(int'(a) * 3);
    endfunction

    // SRAM macro: RD_LAT-cycle registered read on both ports.
    logic [DATA_W-1:0] sa_q [RD_LAT] = '{default: '0};
    logic [DATA_W-1:0] sb_q [RD_LAT] = '{default: '0};
    always @(posedge clock) begin
        sa_q[0] <= sram_word(sram_addr_a);
        sb_q[0] <= sram_word(sram_addr_b);
        for (int i = 1; i < RD_LAT; i++) begin
            sa_q[i] <= sa_q[i-1];
            sb_q[i] <= sb_q[i-1];
        end
    end
    assign sram_rdata_a = sa_q[RD_LAT-1];
    assign sram_rdata_b = sb_q[RD_LAT-1];

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    req_t              inflight[$];
    ent_t              mq[$];
    int                edge_n     = 0;
    logic              m_re       = 1'b0;
    logic [ADDR_W-1:0] m_a        = '0;
    logic [ADDR_W-1:0] m_b        = '0;
    logic              m_ovf      = 1'b0;
    int                m_drops    = 0;
    logic              m_perr     = 1'b0;
    logic              m_has_prev = 1'b0;
    logic [ADDR_W-1:0] m_prev     = '0;

    task automatic cycle(input logic v, input logic [ADDR_W-1:0] e, input logic [ADDR_W-1:0] o,
                         input logic rdy, input logic rst);
        logic pop;
        reset           = rst;
        addr_valid      = v;
        addr_even       = e;
        addr_odd        = o;
        out_if.out_ready = rdy;
        @(posedge clock);
        edge_n++;
        if (rst) begin
            inflight.delete();
            mq.delete();
            m_re = 1'b0; m_a = '0; m_b = '0;
            m_ovf = 1'b0; m_drops = 0;
            m_perr = 1'b0; m_has_prev = 1'b0; m_prev = '0;
        end else begin
            pop = (mq.size() != 0) && rdy;
            if (pop) void'(mq.pop_front());
            if (inflight.size() != 0 && inflight[0].due == edge_n) begin
                req_t r;
                ent_t en;
                r = inflight.pop_front();
                en.addr = r.e;
                en.data = {sram_word(r.o), sram_word(r.e)};
                if (mq.size() < FIFO_DEPTH) begin
                    mq.push_back(en);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drops < 255) m_drops++;
                end
            end
            m_re = v;
            if (v) begin
                req_t nr;
                nr.e = e; nr.o = o; nr.due = edge_n + RD_LAT + 1;
                inflight.push_back(nr);
                m_a = e; m_b = o;
`ifdef PAIR_CHECK_EN
                if (o != ADDR_W'(e + 1) || e[0]) m_perr = 1'b1;
                if (m_has_prev && e != ADDR_W'(m_prev + 2)) m_perr = 1'b1;
                m_prev = e;
                m_has_prev = 1'b1;
`endif
            end
        end
        @(negedge clock);
        check("out_valid", 64'(out_if.out_valid), 64'(mq.size() != 0));
        check("sram_re", 64'(sram_re), 64'(m_re));
        check("sram_addr_a", 64'(sram_addr_a), 64'(m_a));
        check("sram_addr_b", 64'(sram_addr_b), 64'(m_b));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("drop_count", 64'(drop_count), 64'(m_drops));
        check("pair_err", 64'(pair_err), 64'(m_perr));
        if (mq.size() != 0) begin
            check("out_data", 64'(out_if.out_data), 64'(mq[0].data));
            check("out_addr", 64'(out_if.out_addr), 64'(mq[0].addr));
        end
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, '0, '0, rdy, 1'b0);
    endtask

    initial begin
        logic [ADDR_W-1:0] base;
        logic              v, rdy;
        logic [ADDR_W-1:0] e, o;

        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, '0, 1'b0, 1'b1);

        // Streaming with a ready consumer
        cycle(1'b1, 8'd0, 8'd1, 1'b1, 1'b0);
        cycle(1'b1, 8'd2, 8'd3, 1'b1, 1'b0);
        cycle(1'b1, 8'd4, 8'd5, 1'b1, 1'b0);
        repeat (5) idle(1'b1);

        // Overflow: six pairs into a four-entry FIFO with no consumer
        for (int k = 0; k < 6; k++) cycle(1'b1, 8'(2 * k), 8'(2 * k + 1), 1'b0, 1'b0);
        repeat (3) idle(1'b0);
        repeat (6) idle(1'b1);

        // Full FIFO with simultaneous pop and continuous input
        for (int k = 0; k < 4; k++) cycle(1'b1, 8'(20 + 2 * k), 8'(21 + 2 * k), 1'b0, 1'b0);
        repeat (2) idle(1'b0);
        for (int k = 0; k < 12; k++)
            cycle(1'b1, 8'(28 + 2 * k), 8'(29 + 2 * k), (k >= RD_LAT + 1), 1'b0);
        repeat (8) idle(1'b1);

        // Reset with three entries buffered and two reads in flight
        for (int k = 0; k < 3; k++) cycle(1'b1, 8'(100 + 2 * k), 8'(101 + 2 * k), 1'b0, 1'b0);
        repeat (2) idle(1'b0);
        cycle(1'b1, 8'd110, 8'd111, 1'b0, 1'b0);
        cycle(1'b1, 8'd112, 8'd113, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b1);
        repeat (5) idle(1'b1);

        // Address wrap right after reset
        cycle(1'b0, '0, '0, 1'b1, 1'b1);
        cycle(1'b1, 8'd252, 8'd253, 1'b1, 1'b0);
        cycle(1'b1, 8'd254, 8'd255, 1'b1, 1'b0);
        cycle(1'b1, 8'd0, 8'd1, 1'b1, 1'b0);
        repeat (5) idle(1'b1);

        // Randomized traffic: mostly well-formed pairs, occasional corrupt ones
        base = 8'd2;
        for (int k = 0; k < 300; k++) begin
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) begin
                e = 8'($urandom_range(0, 255));
                o = 8'($urandom_range(0, 255));
            end else begin
                e = base;
                o = base + 8'd1;
            end
            if (v) base = e + 8'd2;
            cycle(v, e, o, rdy, 1'b0);
        end
        repeat (8) idle(1'b1);

        // Malformed pair (4,6) right after reset still delivers its data
        cycle(1'b0, '0, '0, 1'b1, 1'b1);
        cycle(1'b1, 8'd4, 8'd6, 1'b1, 1'b0);
        repeat (5) idle(1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sram_pair_fetch.md
Name: sram_pair_fetch

Overview:
Downstream consumer of the even/odd address-pair generator in the SRAM integration path. Each cycle it takes one address pair, issues a dual-port read to the SRAM macro, and tracks the fixed read latency. It joins the two returned words into one pair and buffers the pairs in a small FIFO. The FIFO drains through a valid/ready stream. The upstream generator cannot stall, so the block counts and flags pairs that are lost to overflow.

Parameters:
DATA_W, 16, width of each SRAM read word
ADDR_W, 8, address width (matches the generator)
RD_LAT, 1, SRAM read latency in cycles; legal range 1..4
FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
addr_valid  in  1  address pair present this cycle
addr_even  in  ADDR_W  even address (generator Address1)
addr_odd  in  ADDR_W  odd address (generator Address2)
sram_re  out  1  read enable, both ports
sram_addr_a  out  ADDR_W  port A address
sram_addr_b  out  ADDR_W  port B address
sram_rdata_a  in  DATA_W  port A read data
sram_rdata_b  in  DATA_W  port B read data
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_data  out  2*DATA_W  {rdata_b, rdata_a}
out_addr  out  ADDR_W  even address of the head pair
overflow  out  1  sticky: at least one pair dropped
drop_count  out  8  dropped pairs, saturates at 255
pair_err  out  1  sticky address-pair mismatch (optional feature only)

Behaviour:
- Reset: reset is synchronous and active-high, clock is clock. While reset is high, every output goes to 0, including the FIFO pointers, the latency pipe and the sticky flags. Reset takes effect mid-operation: in-flight reads are discarded and their returned data is ignored.
- Request stage:
  - At edge t0 with addr_valid=1: at t0, sram_re<=1, sram_addr_a<=addr_even, sram_addr_b<=addr_odd.
  - At edge t0 with addr_valid=0: sram_re<=0 and the address outputs hold their values.
  - sram_re has no backpressure. It is issued every valid cycle regardless of FIFO state.
- Latency tracking:
  - A shift register RD_LAT+1 deep carries the valid bit and the even address for each request.
  - Read data is sampled at edge t0+RD_LAT+1. When the tracked valid bit is 1, the pair is a push candidate.
- FIFO:
  - Entry format is {addr, rdata_b, rdata_a}. out_data and out_addr are taken combinationally from the head entry.
  - out_valid = count != 0. When out_valid=0, out_data and out_addr are not checked.
  - Pop occurs when out_valid and out_ready are both 1.
- Push and drop rules:
  - Push succeeds if count < FIFO_DEPTH, or if a pop happens in the same cycle.
  - Full with a simultaneous pop: push and pop both happen and count is unchanged.
  - Full with no pop: the pair is dropped, overflow<=1, and drop_count increments (saturating at 255).
  - Empty with a push: no pop that cycle; out_valid rises at the next edge. There is no bypass.
- Latency: addr_valid sampled at t0 gives out_valid=1 after edge t0+RD_LAT+1, which is RD_LAT+2 edges end to end (3 for RD_LAT=1).
- Pointers: pointers wrap modulo FIFO_DEPTH. count is stored in log2(FIFO_DEPTH)+1 bits.
- Addresses: addresses pass through unmodified. 8-bit wrap (254/255 followed by 0/1) is legal and needs no special handling.
- Ordering: pairs leave the FIFO in request order. Dropped pairs are the newest, never older entries already in the FIFO.

Optional Feature:
- Macro: PAIR_CHECK_EN.
- When defined:
  - Each sampled pair with addr_valid=1 is checked for addr_odd == addr_even+1 (mod 2^ADDR_W) and addr_even[0]==0.
  - A failure sets pair_err<=1 at that edge. pair_err is sticky until reset.
  - A second check compares addr_even against the previous valid addr_even+2 (mod 2^ADDR_W). A mismatch also sets pair_err. This check is skipped for the first valid pair after reset.
- When not defined: pair_err is tied to 0 and the check logic is absent.
- Data flow is identical in both cases.

Test Plan:
- Streaming, RD_LAT=1, out_ready=1: after reset, drive pairs (0,1),(2,3),(4,5) on consecutive cycles with a SRAM model where data = addr*3. Expect out_valid first high 3 edges after the first sample, out_data={3,0},{9,6},{15,12} with out_addr 0,2,4, and drop_count=0.
- Overflow, FIFO_DEPTH=4, out_ready=0: drive 6 consecutive pairs. Expect 4 entries held, overflow=1, drop_count=2. Then raise out_ready and expect addresses 0,2,4,6 in order.
- Full with simultaneous pop: fill the FIFO, then hold out_ready=1 with continuous input. Expect count to stay at 4 and drop_count to stay unchanged.
- Wrap: drive pairs (252,253),(254,255),(0,1). Expect all three delivered in order and pair_err=0 (with PAIR_CHECK_EN).
- Mid-operation reset: assert reset while 2 reads are in flight and 3 entries are buffered. Expect out_valid=0, drop_count=0, overflow=0 on the next edge, and no stale data after reset releases.
- PAIR_CHECK_EN: drive (4,6). Expect pair_err=1 at the next edge and remaining set. Data for (4,6) is still delivered.
